// File: rtl/one_hot_seq_controller.sv
// One-hot start/release sequencer for an iterative shift-and-accumulate datapath.
// Optional one-hot integrity checker (err port) enabled by defining ONEHOT_CHECK_EN.
module one_hot_seq_controller #(
   parameter int unsigned N_ITER = 4,
   parameter int unsigned CNT_W  = $clog2(N_ITER)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             dp_flag,
   output logic             init,
   output logic             ld,
   output logic             calc_en,
   output logic             add_en,
   output logic             shift,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] cnt,
   output logic [6:0]       state
`ifdef ONEHOT_CHECK_EN
   ,
   output logic             err
`endif
);

   // Bit positions of each state inside the one-hot vector.
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StWaitRel = 3'd1,
      StInit    = 3'd2,
      StLoad    = 3'd3,
      StCalc    = 3'd4,
      StShift   = 3'd5,
      StDone    = 3'd6
   } state_bit_e;

   localparam logic [6:0]       IdleVec = 7'b0000001;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_ITER - 1);

   logic [6:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_iter;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IdleVec;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // One flop per state: each next-state bit is the OR of its incoming arcs.
   always_comb begin
      state_d   = '0;
      cnt_d     = cnt_q;
      last_iter = (cnt_q == LastCnt);

      state_d[StIdle]    = (state_q[StIdle] & ~start) | state_q[StDone];
      state_d[StWaitRel] = (state_q[StIdle] | state_q[StWaitRel]) & start;
      state_d[StInit]    = state_q[StWaitRel] & ~start;
      state_d[StLoad]    = state_q[StInit];
      state_d[StCalc]    = state_q[StLoad] | (state_q[StShift] & ~last_iter);
      state_d[StShift]   = state_q[StCalc];
      state_d[StDone]    = state_q[StShift] & last_iter;

      if (state_q[StInit]) begin
         cnt_d = '0;
      end else if (state_q[StShift]) begin
         cnt_d = last_iter ? '0 : cnt_q + CNT_W'(1);
      end

`ifdef ONEHOT_CHECK_EN
      if (err) begin
         state_d = IdleVec;
         cnt_d   = '0;
      end
`endif
   end

`ifdef ONEHOT_CHECK_EN
   assign err = ~$onehot(state_q);
`endif

   assign init    = state_q[StInit];
   assign ld      = state_q[StLoad];
   assign calc_en = state_q[StCalc];
   assign add_en  = state_q[StCalc] & dp_flag;
   assign shift   = state_q[StShift];
   assign busy    = ~state_q[StIdle];
   assign done    = state_q[StDone];
   assign cnt     = cnt_q;
   assign state   = state_q;

endmodule

// File: tb/tb_one_hot_seq_controller.sv
// Self-checking bench: directed scenarios plus random start/dp_flag/rst traffic,
// every cycle compared against a run-position model of the sequencer.
module tb_one_hot_seq_controller;

   localparam int N = 4;
   localparam int CW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst, start, dp_flag;
   logic          init, ld, calc_en, add_en, shift, busy, done;
   logic [CW-1:0] cnt;
   logic [6:0]    state;
`ifdef ONEHOT_CHECK_EN
   logic          err;
`endif

   one_hot_seq_controller #(.N_ITER(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .dp_flag (dp_flag),
      .init    (init),
      .ld      (ld),
      .calc_en (calc_en),
      .add_en  (add_en),
      .shift   (shift),
      .busy    (busy),
      .done    (done),
      .cnt     (cnt),
      .state   (state)
`ifdef ONEHOT_CHECK_EN
      ,
      .err     (err)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: mode 0=idle, 1=waiting for release, 2=running at position step.
   // Run positions: 0 INIT, 1 LOAD, 2..2N+1 alternate CALC/SHIFT, 2N+2 DONE.
   int m_mode = 0;
   int m_step = 0;
   bit chk_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0;
         m_step = 0;
      end else begin
         case (m_mode)
            0: if (start) m_mode = 1;
            1: if (!start) begin m_mode = 2; m_step = 0; end
            default: if (m_step == 2 * N + 2) m_mode = 0; else m_step++;
         endcase
      end
   end

   function automatic int exp_idx();
      if (m_mode == 0) return 0;
      if (m_mode == 1) return 1;
      if (m_step == 0) return 2;
      if (m_step == 1) return 3;
      if (m_step == 2 * N + 2) return 6;
      return (m_step % 2 == 0) ? 4 : 5;
   endfunction

   function automatic int exp_cnt();
      if (m_mode == 2 && m_step >= 2 && m_step <= 2 * N + 1) return (m_step - 2) / 2;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         int idx;
         logic [6:0] ov, ev;
         idx = exp_idx();
         ev  = {idx == 2, idx == 3, idx == 4, (idx == 4) && dp_flag, idx == 5, idx != 0, idx == 6};
         ov  = {init, ld, calc_en, add_en, shift, busy, done};
         check("model_state", 32'(state), 32'(1) << idx);
         check("model_cnt", 32'(cnt), 32'(exp_cnt()));
         check("model_outputs", 32'(ov), 32'(ev));
`ifdef ONEHOT_CHECK_EN
         check("model_err", 32'(err), 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Run observation results.
   int          t_init, t_done, ncalc, nshift, ndone;
   logic [3:0]  addbits;
   logic [31:0] cseq;

   task automatic observe_run(input logic [3:0] pat, input int budget);
      t_init = -1; t_done = -1; ncalc = 0; nshift = 0; ndone = 0;
      addbits = '0; cseq = '0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (state[2]) t_init = i;
         if (calc_en) begin
            if (ncalc < 4) dp_flag = pat[ncalc];
            #1;
            if (ncalc < 4) addbits[ncalc] = add_en;
            ncalc++;
         end
         if (shift) begin
            if (nshift < 8) cseq = cseq | (32'(cnt) << (4 * nshift));
            nshift++;
         end
         if (done) begin
            ndone++;
            t_done = i;
            break;
         end
      end
      if (t_done < 0) check("run_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int nd;
      rst = 1'b1; start = 1'b0; dp_flag = 1'b0;

      // 1. Reset then idle.
      tick(); tick();
      rst = 1'b0;
      chk_en = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_state", 32'(state), 32'h01);
         check("idle_busy_done_cnt", {busy, done, 30'(cnt)}, 32'd0);
      end

      // 2. Normal run, dp_flag held high.
      dp_flag = 1'b1;
      start = 1'b1;
      tick(); tick(); tick();
      check("wait_rel_state", 32'(state), 32'h02);
      start = 1'b0;
      observe_run(4'b1111, 40);
      check("run_latency", 32'(t_done - t_init), 32'd10);
      check("run_calc_count", 32'(ncalc), 32'd4);
      check("run_shift_count", 32'(nshift), 32'd4);
      check("run_add_bits", 32'(addbits), 32'hF);
      check("run_cnt_seq", cseq, 32'h3210);
      tick();
      check("after_done_busy", 32'(busy), 32'd0);
      check("after_done_state", 32'(state), 32'h01);

      // 3. dp_flag pattern 1,0,1,0.
      start = 1'b1; tick(); start = 1'b0;
      observe_run(4'b0101, 40);
      check("pat_add_bits", 32'(addbits), 32'h5);
      check("pat_calc_count", 32'(ncalc), 32'd4);
      check("pat_done_count", 32'(ndone), 32'd1);
      tick();

      // 4. Reset during second SHIFT.
      start = 1'b1; tick(); start = 1'b0;
      nd = 0;
      for (int i = 0; i < 40 && nd < 2; i++) begin
         tick();
         if (shift) nd++;
      end
      check("reached_2nd_shift", 32'(nd), 32'd2);
      rst = 1'b1; tick(); rst = 1'b0;
      check("midrun_rst_state", 32'(state), 32'h01);
      check("midrun_rst_cnt", 32'(cnt), 32'd0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done) nd++;
      end
      check("midrun_no_done", 32'(nd), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      observe_run(4'b1111, 40);
      check("rerun_calc_count", 32'(ncalc), 32'd4);
      check("rerun_done_count", 32'(ndone), 32'd1);
      tick();

      // 5. start held high through completion.
      start = 1'b1; tick(); start = 1'b0; tick();
      start = 1'b1;
      observe_run(4'b1111, 40);
      tick();
      check("held_idle", 32'(state), 32'h01);
      tick();
      check("held_wait_rel", 32'(state), 32'h02);
      for (int i = 0; i < 3; i++) tick();
      check("held_still_waiting", 32'(state), 32'h02);
      start = 1'b0; tick();
      check("held_release_init", 32'(state), 32'h04);
      observe_run(4'b0011, 40);
      tick();

`ifdef ONEHOT_CHECK_EN
      // 6. Illegal state vector recovery.
      chk_en = 0;
      dut.state_q = 7'b0011000;
      #1;
      check("err_flag", 32'(err), 32'd1);
      tick();
      check("err_recover_state", 32'(state), 32'h01);
      check("err_recover_cnt", 32'(cnt), 32'd0);
      check("err_cleared", 32'(err), 32'd0);
      chk_en = 1;
`endif

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) start = ~start;
         dp_flag = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 150) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
